// File: rtl/delay_select_serializer.sv
// -----------------------------------------------------------------------------
// delay_select_serializer
//
// Upstream feeder for the 5 ns pulse-shift stage. It packs two 5-bit delay
// codes into the 10-bit frame W = {DelayY, DelayX}. The frame goes out LSB
// first on outData, and outDataClock is derived by dividing Clock. A frame
// requested while one is in flight is held in a one-deep pending buffer,
// where the latest request wins. Done pulses for one cycle at the end of
// every frame.
//
// Parameters:
//   CLK_DIV     system clocks per half-period of outDataClock (1..255)
//   GAP_CYCLES  idle clocks after the last serial clock falls, before Done
//               (1..255)
//
// Ports:
//   Clock         in   system clock, rising edge
//   Reset         in   asynchronous active-high reset
//   DelayX[4:0]   in   X-group code, frame bits [4:0]
//   DelayY[4:0]   in   Y-group code, frame bits [9:5]
//   Load          in   single-cycle transmit request
//   outDataClock  out  serial clock; the shift stage samples on its rise
//   outData       out  serial data
//   Busy          out  frame in flight
//   Pending       out  queued frame waiting
//   Done          out  one-cycle end-of-frame strobe
//
// Optional feature: define DELAY_SER_SKIP_UNCHANGED_EN to suppress
// retransmission of a word equal to the last fully sent one. In that case
// only a Done pulse is produced.
// -----------------------------------------------------------------------------
module delay_select_serializer #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [4:0] DelayX,
  input  logic [4:0] DelayY,
  input  logic       Load,
  output logic       outDataClock,
  output logic       outData,
  output logic       Busy,
  output logic       Pending,
  output logic       Done
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, GAP} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  state_t     state_q, state_d;
  logic [9:0] word_q, word_d;
  logic [9:0] pend_word_q, pend_word_d;
  logic       pend_q, pend_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] bit_q, bit_d;
  logic       sclk_q, sclk_d;
  logic       sdata_q, sdata_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [9:0] load_word;
  logic [9:0] start_word;

`ifdef DELAY_SER_SKIP_UNCHANGED_EN
  logic [9:0] last_q, last_d;
  logic       last_vld_q, last_vld_d;
`endif

  assign load_word = {DelayY, DelayX};

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      word_q      <= '0;
      pend_word_q <= '0;
      pend_q      <= 1'b0;
      cnt_q       <= '0;
      bit_q       <= '0;
      sclk_q      <= 1'b0;
      sdata_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef DELAY_SER_SKIP_UNCHANGED_EN
      last_q      <= '0;
      last_vld_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      pend_word_q <= pend_word_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      sclk_q      <= sclk_d;
      sdata_q     <= sdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef DELAY_SER_SKIP_UNCHANGED_EN
      last_q      <= last_d;
      last_vld_q  <= last_vld_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    pend_word_d = pend_word_q;
    pend_d      = pend_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    done_d      = 1'b0;
    start_word  = load_word;
`ifdef DELAY_SER_SKIP_UNCHANGED_EN
    last_d      = last_q;
    last_vld_d  = last_vld_q;
`endif

    // Requests arriving mid-frame are queued; the newest one replaces the old.
    if (Load && (state_q != IDLE)) begin
      pend_word_d = load_word;
      pend_d      = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (Load || pend_q) begin
          // Fresh inputs take priority over a queued word.
          start_word = Load ? load_word : pend_word_q;
          pend_d     = 1'b0;
          word_d     = start_word;
          bit_d      = '0;
          cnt_d      = '0;
`ifdef DELAY_SER_SKIP_UNCHANGED_EN
          if (last_vld_q && (start_word == last_q)) begin
            done_d = 1'b1;
          end else begin
            state_d = LOW;
          end
`else
          state_d = LOW;
`endif
        end
      end
      LOW: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          state_d = HIGH;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HIGH: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (bit_q == 4'd9) begin
            state_d = GAP;
          end else begin
            bit_d   = bit_q + 4'd1;
            state_d = LOW;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = IDLE;
`ifdef DELAY_SER_SKIP_UNCHANGED_EN
          last_d     = word_q;
          last_vld_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state, so they carry no decode
    // glitches but keep the same timing as the state itself.
    sclk_d  = (state_d == HIGH);
    sdata_d = ((state_d == LOW) || (state_d == HIGH)) ? word_d[bit_d] : 1'b0;
    busy_d  = (state_d != IDLE);
  end

  assign outDataClock = sclk_q;
  assign outData      = sdata_q;
  assign Busy         = busy_q;
  assign Pending      = pend_q;
  assign Done         = done_q;

endmodule

// File: tb/tb_delay_select_serializer.sv
// -----------------------------------------------------------------------------
// tb_delay_select_serializer
//
// Directed bench for delay_select_serializer. dut_a uses CLK_DIV=2 and
// GAP_CYCLES=2; dut_b uses CLK_DIV=1 and GAP_CYCLES=1. Cycle 0 is the cycle
// in which Load is high. Inputs are driven on the falling edge, and outputs
// are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_delay_select_serializer;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [4:0] dx, dy;
  logic       load_a, load_b;
  logic       a_clk, a_dat, a_busy, a_pend, a_done;
  logic       b_clk, b_dat, b_busy, b_pend, b_done;

  always #5 Clock = ~Clock;

  delay_select_serializer #(.CLK_DIV(2), .GAP_CYCLES(2)) dut_a (
    .Clock(Clock), .Reset(Reset), .DelayX(dx), .DelayY(dy), .Load(load_a),
    .outDataClock(a_clk), .outData(a_dat), .Busy(a_busy),
    .Pending(a_pend), .Done(a_done)
  );

  delay_select_serializer #(.CLK_DIV(1), .GAP_CYCLES(1)) dut_b (
    .Clock(Clock), .Reset(Reset), .DelayX(dx), .DelayY(dy), .Load(load_b),
    .outDataClock(b_clk), .outData(b_dat), .Busy(b_busy),
    .Pending(b_pend), .Done(b_done)
  );

  logic sel;
  wire  m_clk  = sel ? b_clk  : a_clk;
  wire  m_dat  = sel ? b_dat  : a_dat;
  wire  m_busy = sel ? b_busy : a_busy;
  wire  m_pend = sel ? b_pend : a_pend;
  wire  m_done = sel ? b_done : a_done;

  int checks   = 0;
  int failures = 0;

  // Observations gathered by the monitor. m_sreg models the downstream
  // right-shifting register, so it persists across frames and resets.
  logic [9:0] m_sreg = '0;
  logic [9:0] m_w1, m_w2;
  int m_edges, m_nfall, m_done_cnt, m_done1, m_done2, m_viol;
  int m_rise[20];
  int m_fall[20];
  bit m_pend_seen, m_busy_seen;

  task automatic monitor(input int ncyc);
    logic pc, pd;
    m_edges = 0; m_nfall = 0; m_done_cnt = 0; m_done1 = -1; m_done2 = -1;
    m_viol = 0; m_pend_seen = 0; m_busy_seen = 0; m_w1 = '0; m_w2 = '0;
    pc = 1'b0; pd = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge Clock);
      if (m_clk && !pc) begin
        if (m_edges < 10) m_w1[m_edges] = m_dat;
        else if (m_edges < 20) m_w2[m_edges-10] = m_dat;
        if (m_edges < 20) m_rise[m_edges] = c;
        m_edges++;
        m_sreg = {m_dat, m_sreg[9:1]};
      end
      if (!m_clk && pc) begin
        if (m_nfall < 20) m_fall[m_nfall] = c;
        m_nfall++;
      end
      if ((m_dat !== pd) && m_clk) m_viol++;
      if (m_done) begin
        m_done_cnt++;
        if (m_done_cnt == 1) m_done1 = c;
        else if (m_done_cnt == 2) m_done2 = c;
      end
      if (m_pend) m_pend_seen = 1;
      if (m_busy) m_busy_seen = 1;
      pc = m_clk;
      pd = m_dat;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; load_a = 1'b0; load_b = 1'b0; dx = '0; dy = '0; sel = 1'b0;
    repeat (3) @(negedge Clock);
    checks++;
    if ({a_clk, a_dat, a_busy, a_pend, a_done} !== 5'b0) begin
      failures++;
      $display("FAIL reset_a: got %b expected 00000", {a_clk, a_dat, a_busy, a_pend, a_done});
    end
    checks++;
    if ({b_clk, b_dat, b_busy, b_pend, b_done} !== 5'b0) begin
      failures++;
      $display("FAIL reset_b: got %b expected 00000", {b_clk, b_dat, b_busy, b_pend, b_done});
    end
    Reset = 1'b0;
    repeat (2) @(negedge Clock);
    checks++;
    if ({a_clk, a_busy, a_done} !== 3'b0) begin
      failures++;
      $display("FAIL reset_idle: got %b expected 000", {a_clk, a_busy, a_done});
    end
    $display("reset: outputs a=%b b=%b", {a_clk, a_dat, a_busy, a_pend, a_done},
             {b_clk, b_dat, b_busy, b_pend, b_done});
  endtask

  task automatic test_basic();
    int bad;
    sel = 1'b0;
    @(negedge Clock);
    dx = 5'b00011; dy = 5'b10000; load_a = 1'b1;
    fork
      monitor(60);
      begin @(negedge Clock); load_a = 1'b0; end
    join
    $display("basic: W sent=%h edges=%0d done@%0d sreg=%h", m_w1, m_edges, m_done1, m_sreg);
    checks++;
    if (m_edges !== 10) begin failures++; $display("FAIL basic_edges: got %0d expected 10", m_edges); end
    checks++;
    if (m_w1 !== 10'h203) begin failures++; $display("FAIL basic_bits: got %h expected 203", m_w1); end
    checks++;
    if (m_sreg !== 10'h203) begin failures++; $display("FAIL basic_sreg: got %h expected 203", m_sreg); end
    checks++;
    if (m_done1 !== 43 || m_done_cnt !== 1) begin
      failures++; $display("FAIL basic_done: got cycle %0d count %0d expected 43 1", m_done1, m_done_cnt);
    end
    bad = 0;
    for (int k = 0; k < 10; k++) if (m_rise[k] != 3 + 4*k) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL basic_rise_timing: got %0d bad edges expected 0", bad); end
    checks++;
    if (m_viol !== 0) begin failures++; $display("FAIL basic_data_stable: got %0d changes while high expected 0", m_viol); end
  endtask

  task automatic test_pending();
    sel = 1'b0;
    @(negedge Clock);
    dx = 5'd1; dy = 5'd1; load_a = 1'b1;
    fork
      monitor(100);
      begin
        @(negedge Clock); load_a = 1'b0;
        repeat (4) @(negedge Clock);
        dx = 5'd7; dy = 5'd2; load_a = 1'b1;
        @(negedge Clock); load_a = 1'b0;
        repeat (4) @(negedge Clock);
        dx = 5'd31; dy = 5'd31; load_a = 1'b1;
        @(negedge Clock); load_a = 1'b0;
      end
    join
    $display("pending: W1=%h W2=%h edges=%0d done@%0d,%0d", m_w1, m_w2, m_edges, m_done1, m_done2);
    checks++;
    if (m_pend_seen !== 1'b1) begin failures++; $display("FAIL pend_flag: got %0d expected 1", m_pend_seen); end
    checks++;
    if (m_w1 !== 10'h021) begin failures++; $display("FAIL pend_first_word: got %h expected 021", m_w1); end
    checks++;
    if (m_w2 !== 10'h3FF || m_sreg !== 10'h3FF) begin
      failures++; $display("FAIL pend_second_word: got %h/%h expected 3ff", m_w2, m_sreg);
    end
    checks++;
    if (m_edges !== 20 || m_done_cnt !== 2) begin
      failures++; $display("FAIL pend_counts: got edges %0d dones %0d expected 20 2", m_edges, m_done_cnt);
    end
    checks++;
    if (m_done1 !== 43 || m_done2 !== 86) begin
      failures++; $display("FAIL pend_done_cycles: got %0d,%0d expected 43,86", m_done1, m_done2);
    end
    checks++;
    if (m_rise[10] !== 46) begin failures++; $display("FAIL pend_second_start: got %0d expected 46", m_rise[10]); end
    checks++;
    if (a_pend !== 1'b0) begin failures++; $display("FAIL pend_cleared: got %b expected 0", a_pend); end
  endtask

  task automatic test_midframe_reset();
    int   rises;
    logic pc;
    sel = 1'b0;
    @(negedge Clock);
    dx = 5'd31; dy = 5'd0; load_a = 1'b1;
    @(negedge Clock); load_a = 1'b0;
    rises = 0; pc = a_clk;
    for (int c = 0; c < 60 && rises < 4; c++) begin
      @(negedge Clock);
      if (a_clk && !pc) begin rises++; m_sreg = {a_dat, m_sreg[9:1]}; end
      pc = a_clk;
    end
    checks++;
    if (rises !== 4 || a_busy !== 1'b1 || a_clk !== 1'b1) begin
      failures++; $display("FAIL rst_reach_4th: got rises %0d busy %b clk %b expected 4 1 1", rises, a_busy, a_clk);
    end
    #1 Reset = 1'b1;
    #1;
    checks++;
    if ({a_clk, a_dat, a_busy, a_pend, a_done} !== 5'b0) begin
      failures++; $display("FAIL rst_async: got %b expected 00000", {a_clk, a_dat, a_busy, a_pend, a_done});
    end
    $display("midreset: aborted after %0d edges, outputs=%b", rises, {a_clk, a_dat, a_busy, a_pend, a_done});
    @(negedge Clock); Reset = 1'b0;
    @(negedge Clock);
    dx = 5'd5; dy = 5'd9; load_a = 1'b1;
    fork
      monitor(50);
      begin @(negedge Clock); load_a = 1'b0; end
    join
    $display("midreset: repair frame sreg=%h done@%0d", m_sreg, m_done1);
    checks++;
    if (m_sreg !== 10'h125) begin failures++; $display("FAIL rst_repair_sreg: got %h expected 125", m_sreg); end
    checks++;
    if (m_edges !== 10 || m_done1 !== 43) begin
      failures++; $display("FAIL rst_repair_frame: got edges %0d done %0d expected 10 43", m_edges, m_done1);
    end
  endtask

  task automatic test_divider_boundary();
    int bad;
    sel = 1'b1;
    @(negedge Clock);
    dx = 5'd0; dy = 5'd0; load_b = 1'b1;
    fork
      monitor(30);
      begin @(negedge Clock); load_b = 1'b0; end
    join
    $display("divider: edges=%0d done@%0d sreg=%h", m_edges, m_done1, m_sreg);
    checks++;
    if (m_edges !== 10) begin failures++; $display("FAIL div_edges: got %0d expected 10", m_edges); end
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (m_rise[k] != 2 + 2*k) bad++;
      if (m_fall[k] != 3 + 2*k) bad++;
    end
    checks++;
    if (bad != 0 || m_nfall !== 10) begin
      failures++; $display("FAIL div_timing: got %0d bad edges, %0d falls expected 0 10", bad, m_nfall);
    end
    checks++;
    if (m_done1 !== 22 || m_done_cnt !== 1) begin
      failures++; $display("FAIL div_done: got cycle %0d count %0d expected 22 1", m_done1, m_done_cnt);
    end
    checks++;
    if (m_sreg !== 10'h000) begin failures++; $display("FAIL div_sreg: got %h expected 000", m_sreg); end
    sel = 1'b0;
  endtask

  task automatic test_simultaneous();
    sel = 1'b0;
    @(negedge Clock);
    dx = 5'd1; dy = 5'd2; load_a = 1'b1;
    fork
      monitor(140);
      begin
        @(negedge Clock); load_a = 1'b0;
        repeat (9) @(negedge Clock);
        dx = 5'd3; dy = 5'd3; load_a = 1'b1;
        @(negedge Clock); load_a = 1'b0;
        repeat (32) @(negedge Clock);
        checks++;
        if (a_done !== 1'b1 || a_pend !== 1'b1) begin
          failures++; $display("FAIL sim_align: got done %b pending %b expected 1 1", a_done, a_pend);
        end
        dx = 5'd10; dy = 5'd21; load_a = 1'b1;
        @(negedge Clock); load_a = 1'b0;
      end
    join
    $display("simultaneous: W1=%h W2=%h edges=%0d dones=%0d", m_w1, m_w2, m_edges, m_done_cnt);
    checks++;
    if (m_w1 !== 10'h041) begin failures++; $display("FAIL sim_first_word: got %h expected 041", m_w1); end
    checks++;
    if (m_w2 !== 10'h2AA) begin failures++; $display("FAIL sim_second_word: got %h expected 2aa", m_w2); end
    checks++;
    if (m_edges !== 20 || m_done_cnt !== 2 || m_done2 !== 86) begin
      failures++; $display("FAIL sim_no_stale: got edges %0d dones %0d done2 %0d expected 20 2 86", m_edges, m_done_cnt, m_done2);
    end
    checks++;
    if (a_pend !== 1'b0) begin failures++; $display("FAIL sim_pend_cleared: got %b expected 0", a_pend); end
  endtask

  task automatic send_x3y4(input int ncyc);
    sel = 1'b0;
    @(negedge Clock);
    dx = 5'd3; dy = 5'd4; load_a = 1'b1;
    fork
      monitor(ncyc);
      begin @(negedge Clock); load_a = 1'b0; end
    join
    $display("repeat: W=%h edges=%0d done@%0d busy_seen=%0d", m_w1, m_edges, m_done1, m_busy_seen);
  endtask

  task automatic test_repeat_word();
    send_x3y4(50);
    checks++;
    if (m_edges !== 10 || m_w1 !== 10'h083 || m_done1 !== 43) begin
      failures++; $display("FAIL rep_first: got edges %0d word %h done %0d expected 10 083 43", m_edges, m_w1, m_done1);
    end
`ifdef DELAY_SER_SKIP_UNCHANGED_EN
    send_x3y4(10);
    checks++;
    if (m_edges !== 0 || m_busy_seen !== 1'b0) begin
      failures++; $display("FAIL skip_no_clocks: got edges %0d busy %0d expected 0 0", m_edges, m_busy_seen);
    end
    checks++;
    if (m_done1 !== 1 || m_done_cnt !== 1) begin
      failures++; $display("FAIL skip_done: got cycle %0d count %0d expected 1 1", m_done1, m_done_cnt);
    end
    @(negedge Clock); Reset = 1'b1;
    @(negedge Clock); Reset = 1'b0;
    send_x3y4(50);
    checks++;
    if (m_edges !== 10 || m_w1 !== 10'h083 || m_done1 !== 43) begin
      failures++; $display("FAIL skip_after_reset: got edges %0d word %h done %0d expected 10 083 43", m_edges, m_w1, m_done1);
    end
`else
    send_x3y4(50);
    checks++;
    if (m_edges !== 10 || m_w1 !== 10'h083 || m_done1 !== 43) begin
      failures++; $display("FAIL rep_second: got edges %0d word %h done %0d expected 10 083 43", m_edges, m_w1, m_done1);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pending();
    test_midframe_reset();
    test_divider_boundary();
    test_simultaneous();
    test_repeat_word();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/delay_select_serializer.md
Name: delay_select_serializer

Overview:
- Upstream feeder for the 5 ns pulse-shift stage.
- Takes two parallel 5-bit delay codes (X group, Y group) from the control logic and serialises them into the 10-bit frame that the shift stage clocks in on its data-clock/data pins.
- Generates the serial clock by dividing the system clock, with a load handshake, one-deep pending buffer and end-of-frame strobe.
- Code 0 (bypass) is a legal value and is sent like any other.

Parameters:
- CLK_DIV, 4: system clocks per half-period of outDataClock; legal 1..255.
- GAP_CYCLES, 2: idle system clocks after the last serial clock falls, before Done; legal 1..255.

Ports:
- Clock  input  1  system clock; all logic on its rising edge.
- Reset  input  1  asynchronous, active-high reset.
- DelayX  input  5  X-group delay code; lands in shift-stage select bits [4:0].
- DelayY  input  5  Y-group delay code; lands in shift-stage select bits [9:5].
- Load  input  1  single-cycle request to transmit {DelayY, DelayX}.
- outDataClock  output  1  serial clock to the shift stage; it samples on the rising edge.
- outData  output  1  serial data to the shift stage.
- Busy  output  1  high while a frame is in flight.
- Pending  output  1  high while a queued frame waits.
- Done  output  1  one-cycle strobe at the end of each frame.

Behaviour:
Reset values:
- Reset asserted: outDataClock=0, outData=0, Busy=0, Pending=0, Done=0.
- Shift register, counters and pending word clear; FSM goes to IDLE.
- Reset mid-frame aborts immediately. The downstream register may hold a partial shift; the next full frame repairs it.

Frame format:
- Frame word W = {DelayY, DelayX}, captured on the Load cycle.
- Sent LSB first: W[0] first, W[9] last. The downstream right-shifting register then holds W exactly after 10 rising edges.

FSM states: IDLE, LOW, HIGH, GAP.
- IDLE: if Load or Pending, capture W (from inputs if Load, else from the pending word), clear Pending, set Busy=1, bit counter=0, go to LOW.
- LOW: outDataClock=0, outData=W[bit] stable for the whole state. After CLK_DIV cycles go to HIGH.
- HIGH: outDataClock=1, outData unchanged (hold time). After CLK_DIV cycles:
  - if bit=9, go to GAP;
  - else bit+1 and go to LOW.
- GAP: outDataClock=0, outData=0 for GAP_CYCLES cycles. On the last GAP cycle, Done=1 for one cycle; go to IDLE, where Busy=0.

Timing:
- Latency from the Load cycle to Done = 1 + 20*CLK_DIV + GAP_CYCLES cycles.
- Exactly 10 outDataClock rising edges per frame.
- outData changes only while outDataClock=0.

Pending buffer:
- Load while Busy=1: latch {DelayY, DelayX} into the pending word and set Pending=1.
- Further Loads while busy overwrite it (latest wins).
- The queued frame starts in the IDLE cycle right after Done. No Load is ever dropped silently; only superseded.
- Load in IDLE and Pending=1 together: the inputs win and Pending is cleared.

Counters:
- Half-period counter 8 bits; bit counter 4 bits.
- No wrap beyond 9; bit counter resets to 0 on each frame start.

Optional Feature:
- Macro: DELAY_SER_SKIP_UNCHANGED_EN.
- Defined:
  - Keep a 10-bit copy of the last fully transmitted W, plus a valid flag cleared by Reset and set on Done.
  - A frame start whose W equals the stored copy (valid=1) sends no clocks. Busy stays 0, and Done pulses once in the following cycle.
  - An aborted frame (Reset) never updates the copy.
- Undefined: every request transmits a full frame.

Test Plan:
- Basic frame:
  - Setup: CLK_DIV=2, GAP=2; Load with X=5'b00011, Y=5'b10000.
  - Required: outData at the 10 rising edges = 1,1,0,0,0,0,0,0,0,1.
  - Required: model shift register ends at 10'h203; Done exactly 43 cycles after the Load cycle.
- Pending buffer:
  - Setup: Load X=1,Y=1; then two Loads while busy (X=7,Y=2, then X=31,Y=31).
  - Required: Pending=1; second frame sends 10'h3FF and starts in the cycle after the first Done; exactly 2 Done pulses.
- Mid-frame reset:
  - Setup: Reset asserted after the 4th rising edge.
  - Required: all outputs 0 asynchronously; then Load X=5,Y=9 gives model register 10'h125 after Done.
- Divider boundary:
  - Setup: CLK_DIV=1, GAP=1; Load X=0,Y=0.
  - Required: 10 clocks, each high 1 cycle and low 1 cycle; Done at cycle 22; register 10'h000.
- Simultaneous events:
  - Setup: Load asserted in the same cycle as Done with Pending=1.
  - Required: the new Load replaces the pending word; only that value is sent next.
- Skip unchanged (DELAY_SER_SKIP_UNCHANGED_EN defined):
  - Setup: Load X=3,Y=4 twice with a full frame between.
  - Required: second request gives zero outDataClock edges and a Done 1 cycle later.
  - Required: after a Reset, the same value is transmitted again in full.
